// File: rtl/sram_arb_pkg.sv
// rtl/sram_arb_pkg.sv - shared types for the SRAM port arbiter
package sram_arb_pkg;

  localparam int ARB_ADDR_W = 16;
  localparam int ARB_DATA_W = 8;

  // Which engine owns a command or a returning read word
  typedef enum logic {
    REQ_RC4 = 1'b0,
    REQ_ED  = 1'b1
  } requester_t;

  // One SRAM access as it is registered onto the pins
  typedef struct packed {
    logic                  wen;
    logic [ARB_ADDR_W-1:0] addr;
    logic [ARB_DATA_W-1:0] wdata;
  } mem_cmd_t;

  // Per-stage read tracking entry
  typedef struct packed {
    logic       valid;
    requester_t id;
  } tag_t;

endpackage

// File: rtl/rd_tag_pipe.sv
// rtl/rd_tag_pipe.sv - fixed-latency shift register tracking in-flight read owners
module rd_tag_pipe
  import sram_arb_pkg::*;
#(
  parameter int READ_LAT = 2
) (
  input  logic clk,
  input  logic rst,
  input  tag_t tag_in,
  output tag_t tag_out,
  output logic any_valid
);

  tag_t stage [READ_LAT];

  // Shift tags one stage per cycle; reset drops every in-flight read
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < READ_LAT; i++) begin
        stage[i] <= '0;
      end
    end else begin
      stage[0] <= tag_in;
      for (int i = 1; i < READ_LAT; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  // Any stage holding a live read keeps the port busy
  always_comb begin
    any_valid = 1'b0;
    for (int i = 0; i < READ_LAT; i++) begin
      any_valid = any_valid | stage[i].valid;
    end
  end

  assign tag_out = stage[READ_LAT-1];

endmodule

// File: rtl/sram_port_arbiter.sv
// rtl/sram_port_arbiter.sv - round-robin share of one SRAM port between RC4 and edge detection
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W   = ARB_ADDR_W,
  parameter int DATA_W   = ARB_DATA_W,
  parameter int READ_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rc4_req,
  input  logic              rc4_wen,
  input  logic [ADDR_W-1:0] rc4_addr,
  input  logic [DATA_W-1:0] rc4_wdata,
  output logic              rc4_gnt,
  output logic              rc4_rvalid,
  input  logic              ed_req,
  input  logic              ed_wen,
  input  logic [ADDR_W-1:0] ed_addr,
  input  logic [DATA_W-1:0] ed_wdata,
  output logic              ed_gnt,
  output logic              ed_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_en,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  requester_t last_grant;
  mem_cmd_t   sel_cmd;
  mem_cmd_t   cmd_q;
  requester_t sel_id;
  requester_t id_q;
  logic       mem_en_q;
  logic       any_gnt;
  tag_t       tag_in;
  tag_t       tag_out;
  logic       tags_busy;

  // Round-robin grant: a lone requester wins, a tie goes to whoever did not win last
  always_comb begin
    rc4_gnt = 1'b0;
    ed_gnt  = 1'b0;
    if (!rst) begin
      if (rc4_req && ed_req) begin
        rc4_gnt = (last_grant == REQ_ED);
        ed_gnt  = (last_grant == REQ_RC4);
      end else begin
        rc4_gnt = rc4_req;
        ed_gnt  = ed_req;
      end
    end
  end

  assign any_gnt = rc4_gnt | ed_gnt;

  // Select the granted engine's command for the pin register
  always_comb begin
    sel_cmd = '{wen: rc4_wen, addr: rc4_addr, wdata: rc4_wdata};
    sel_id  = REQ_RC4;
    if (ed_gnt) begin
      sel_cmd = '{wen: ed_wen, addr: ed_addr, wdata: ed_wdata};
      sel_id  = REQ_ED;
    end
  end

  // Remember the last actual winner; reset favours RC4 on the first tie
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= REQ_ED;
    end else if (rc4_gnt) begin
      last_grant <= REQ_RC4;
    end else if (ed_gnt) begin
      last_grant <= REQ_ED;
    end
  end

  // Register the granted command onto the pins; idle cycles keep the old command
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_en_q <= 1'b0;
      cmd_q    <= '0;
      id_q     <= REQ_RC4;
    end else begin
      mem_en_q <= any_gnt;
      if (any_gnt) begin
        cmd_q <= sel_cmd;
        id_q  <= sel_id;
      end
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_wen   = cmd_q.wen;
  assign mem_addr  = cmd_q.addr;
  assign mem_wdata = cmd_q.wdata;

  // A read on the pins enters the tag pipe together with its owner
  assign tag_in = '{valid: mem_en_q & ~cmd_q.wen, id: id_q};

  rd_tag_pipe #(
    .READ_LAT (READ_LAT)
  ) u_tag_pipe (
    .clk       (clk),
    .rst       (rst),
    .tag_in    (tag_in),
    .tag_out   (tag_out),
    .any_valid (tags_busy)
  );

  assign rc4_rvalid = tag_out.valid && (tag_out.id == REQ_RC4);
  assign ed_rvalid  = tag_out.valid && (tag_out.id == REQ_ED);
  assign rdata      = mem_rdata;
  assign busy       = mem_en_q | tags_busy;

endmodule

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Shares the single external SRAM port between the RC4 decryption engine and the Sobel edge-detection engine. Round-robin arbitration sustains one access per cycle, and the block registers the granted command onto the SRAM pins. It tracks outstanding reads through a fixed-latency tag pipeline so each read word returns only to its issuer. It sits beside the top-level sequencing MCU, which starts RC4 and then edge detection; during hand-over the two engines may overlap in requesting.

## Interface
- ADDR_W, 16, SRAM word address width
- DATA_W, 8, SRAM data width
- READ_LAT, 2, cycles from mem_en (read) registered at the pins to mem_rdata valid; legal range 1..4
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- rc4_req  in  1  RC4 access request; command held stable until rc4_gnt
- rc4_wen  in  1  1 = write, 0 = read
- rc4_addr  in  ADDR_W  access address
- rc4_wdata  in  DATA_W  write data
- rc4_gnt  out  1  combinational grant; command is accepted this cycle
- rc4_rvalid  out  1  read data for RC4 valid on rdata this cycle
- ed_req, ed_wen, ed_addr, ed_wdata  in  1/1/ADDR_W/DATA_W  same semantics for edge detection
- ed_gnt, ed_rvalid  out  1/1  same semantics for edge detection
- rdata  out  DATA_W  mem_rdata broadcast to both engines; qualify with *_rvalid
- mem_en  out  1  registered SRAM access strobe
- mem_wen  out  1  registered write enable
- mem_addr  out  ADDR_W  registered address
- mem_wdata  out  DATA_W  registered write data
- mem_rdata  in  DATA_W  SRAM read data
- busy  out  1  high while mem_en is set or any read is in flight

## Operation
- Arbitration (combinational):
  - Only one requester active: it is granted.
  - Both active: grant the one not granted most recently.
  - last_grant register updates only on an actual grant; reset value = ED, so RC4 wins the first contested cycle.
- Grant uniqueness: at most one *_gnt per cycle; no grant when neither *_req is set.
- Issue: on a grant edge, mem_en←1 and mem_wen/addr/wdata←granted command. With no grant, mem_en←0 and the other mem_* hold their previous values.
- Read tagging:
  - Tag pipeline of depth READ_LAT; each stage is {valid, id}.
  - Stage 0 loads {mem_en & ~mem_wen, id of the issuing requester}.
  - The final stage drives rc4_rvalid or ed_rvalid.
  - Writes produce no rvalid.
- Ordering: responses return in issue order. Back-to-back reads from different requesters interleave correctly with no bubble.
- busy = mem_en | OR of all tag-stage valids.

## Timing
- Grant-to-pin latency: 1 cycle. Command granted in cycle N appears on mem_* in N+1.
- Read latency at requester: rvalid in cycle N+1+READ_LAT for a read granted in N. rdata is combinational from mem_rdata.
- Throughput: 1 access/cycle. A requester holding req continuously, with no competitor, is granted every cycle.
- Under contention with both requesting continuously, grants alternate RC4, ED, RC4, ...
- Reset values: mem_en=0, mem_wen=0, mem_addr=0, mem_wdata=0, all tag stages invalid, rc4_rvalid=ed_rvalid=0, busy=0, last_grant=ED.
- rst asserted mid-operation:
  - In-flight reads are discarded; no rvalid is produced after the reset edge.
  - mem_en=0 in the cycle after the reset edge.
  - *_gnt are forced 0 while rst=1.
- Simultaneous grant and returning rvalid: independent. An engine may receive rvalid and gnt in the same cycle.

## Structure
- Package sram_arb_pkg:
  - requester_t enum {REQ_RC4, REQ_ED}
  - mem_cmd_t struct {wen, addr, wdata}
  - tag_t struct {valid, requester_t id}
- Sub-module rd_tag_pipe: parameterised READ_LAT shift register of tag_t with synchronous clear. It outputs the final-stage tag; the top level decodes it into the two rvalids.
- Top level contains the round-robin logic, last_grant register, command output register and busy.

## Test plan
- Reset → mem_en=0, both gnt=0, both rvalid=0, busy=0; hold 2 cycles, values stable.
- RC4 alone, read addr 0x0010, SRAM returns 0xA5 → rc4_gnt same cycle, mem_en/mem_addr=0x0010 next cycle, rc4_rvalid with rdata=0xA5 exactly 1+READ_LAT cycles after grant, ed_rvalid stays 0.
- Both request reads continuously (RC4 addr 0x0001, ED addr 0x0100) for 6 cycles → grants RC4,ED,RC4,ED,RC4,ED; rvalids alternate in the same order, each tagged to the correct engine.
- ED write 0x3C to 0x0200, then RC4 read 0x0200 → mem_wen=1 then 0 on consecutive cycles; no rvalid for the write; rc4_rvalid with 0x3C.
- Two RC4 reads in flight, then rst=1 for 1 cycle → no rvalid afterward, busy=0 after reset, first contested grant post-reset goes to RC4.
- ED requesting alone, RC4 raises req in the cycle ED is granted → ED's accepted command issues intact; the next contested cycle grants RC4.
